// File: rtl/branch_predictor_if.sv
// rtl/branch_predictor_if.sv - IF lookup and EX resolve signal bundle for branch_predictor
interface branch_predictor_if #(
  parameter int WORD_SIZE = 16
);
  logic [WORD_SIZE-1:0] if_pc;
  logic [WORD_SIZE-1:0] if_pred_pc;
  logic                 if_pred_taken;
  logic                 ex_valid;
  logic                 ex_is_branch;
  logic                 ex_is_jump;
  logic [WORD_SIZE-1:0] ex_pc;
  logic                 ex_taken;
  logic [WORD_SIZE-1:0] ex_target;
  logic [WORD_SIZE-1:0] ex_pred_pc;
  logic                 mispredict;
  logic [WORD_SIZE-1:0] redirect_pc;

  modport master (
    output if_pc, ex_valid, ex_is_branch, ex_is_jump, ex_pc, ex_taken, ex_target, ex_pred_pc,
    input  if_pred_pc, if_pred_taken, mispredict, redirect_pc
  );

  modport slave (
    input  if_pc, ex_valid, ex_is_branch, ex_is_jump, ex_pc, ex_taken, ex_target, ex_pred_pc,
    output if_pred_pc, if_pred_taken, mispredict, redirect_pc
  );
endinterface

// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - direct-mapped BTB predictor with 2-bit counters and EX-side resolver
// Optional BP_STATS_EN adds saturating branch/mispredict statistics counters.
module branch_predictor #(
  parameter int         WORD_SIZE = 16,
  parameter int         IDX_W     = 4,
  parameter logic [1:0] CTR_INIT  = 2'b10
) (
  input  logic                clk,
  input  logic                reset_n,
  branch_predictor_if.slave   bp
`ifdef BP_STATS_EN
  ,
  output logic [15:0]         stat_branches,
  output logic [15:0]         stat_mispredicts
`endif
);
  localparam int ENTRIES = 2 ** IDX_W;
  localparam int TAG_W   = WORD_SIZE - IDX_W;

  logic [ENTRIES-1:0]   valid_q;
  logic [1:0]           ctr_q    [ENTRIES];
  logic [TAG_W-1:0]     tag_q    [ENTRIES];
  logic [WORD_SIZE-1:0] target_q [ENTRIES];

  logic [IDX_W-1:0]     if_idx, ex_idx;
  logic [TAG_W-1:0]     if_tag, ex_tag;
  logic                 if_hit, ex_hit;
  logic [WORD_SIZE-1:0] actual_next;
  logic                 upd_we, tgt_we;
  logic [1:0]           upd_ctr_d;

  assign if_idx = bp.if_pc[IDX_W-1:0];
  assign if_tag = bp.if_pc[WORD_SIZE-1:IDX_W];
  assign ex_idx = bp.ex_pc[IDX_W-1:0];
  assign ex_tag = bp.ex_pc[WORD_SIZE-1:IDX_W];

  // Lookup reads registered state only, so a same-cycle update is not yet visible.
  assign if_hit           = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
  assign bp.if_pred_taken = if_hit && ctr_q[if_idx][1];
  assign bp.if_pred_pc    = bp.if_pred_taken ? target_q[if_idx] : bp.if_pc + WORD_SIZE'(1);

  assign actual_next = (bp.ex_is_jump || (bp.ex_is_branch && bp.ex_taken)) ?
                       bp.ex_target : bp.ex_pc + WORD_SIZE'(1);
  assign bp.mispredict  = reset_n && bp.ex_valid && (bp.ex_is_branch || bp.ex_is_jump) &&
                          (actual_next != bp.ex_pred_pc);
  assign bp.redirect_pc = (reset_n && bp.ex_valid) ? actual_next : '0;

  assign ex_hit = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);

  always_comb begin
    upd_we    = 1'b0;
    tgt_we    = 1'b0;
    upd_ctr_d = ctr_q[ex_idx];
    if (bp.ex_valid) begin
      if (bp.ex_is_jump) begin
        upd_we    = 1'b1;
        tgt_we    = 1'b1;
        upd_ctr_d = 2'b11;
      end else if (bp.ex_is_branch) begin
        if (ex_hit) begin
          upd_we = 1'b1;
          tgt_we = bp.ex_taken;
          if (bp.ex_taken)
            upd_ctr_d = (ctr_q[ex_idx] == 2'b11) ? 2'b11 : ctr_q[ex_idx] + 2'b01;
          else
            upd_ctr_d = (ctr_q[ex_idx] == 2'b00) ? 2'b00 : ctr_q[ex_idx] - 2'b01;
        end else if (bp.ex_taken) begin
          upd_we    = 1'b1;
          tgt_we    = 1'b1;
          upd_ctr_d = CTR_INIT;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= '0;
      for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= 2'b01;
    end else if (upd_we) begin
      valid_q[ex_idx] <= 1'b1;
      ctr_q[ex_idx]   <= upd_ctr_d;
    end
  end

  // Tag/target need no reset: an entry is meaningless until its valid bit is set.
  always_ff @(posedge clk) begin
    if (tgt_we) begin
      tag_q[ex_idx]    <= ex_tag;
      target_q[ex_idx] <= bp.ex_target;
    end
  end

`ifdef BP_STATS_EN
  logic [15:0] stat_branches_q, stat_mispredicts_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stat_branches_q    <= '0;
      stat_mispredicts_q <= '0;
    end else begin
      if (bp.ex_valid && (bp.ex_is_branch || bp.ex_is_jump) && stat_branches_q != 16'hFFFF)
        stat_branches_q <= stat_branches_q + 16'd1;
      if (bp.mispredict && stat_mispredicts_q != 16'hFFFF)
        stat_mispredicts_q <= stat_mispredicts_q + 16'd1;
    end
  end

  assign stat_branches    = stat_branches_q;
  assign stat_mispredicts = stat_mispredicts_q;
`endif
endmodule

// File: tb/tb_branch_predictor.sv
// tb/tb_branch_predictor.sv - directed self-checking bench for branch_predictor
module tb_branch_predictor;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   n_pass = 0;
  int   n_total = 0;

  branch_predictor_if #(.WORD_SIZE(16)) bpi ();

`ifdef BP_STATS_EN
  logic [15:0] stat_branches, stat_mispredicts;
`endif

  branch_predictor #(.WORD_SIZE(16), .IDX_W(4), .CTR_INIT(2'b10)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bp      (bpi.slave)
`ifdef BP_STATS_EN
    ,
    .stat_branches    (stat_branches),
    .stat_mispredicts (stat_mispredicts)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ex(input logic v, input logic br, input logic jmp, input logic [15:0] pc,
                        input logic tk, input logic [15:0] tgt, input logic [15:0] pred);
    bpi.ex_valid     = v;
    bpi.ex_is_branch = br;
    bpi.ex_is_jump   = jmp;
    bpi.ex_pc        = pc;
    bpi.ex_taken     = tk;
    bpi.ex_target    = tgt;
    bpi.ex_pred_pc   = pred;
  endtask

  task automatic idle();
    set_ex(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000);
  endtask

  initial begin
    bpi.if_pc = 16'h0010;
    idle();
    repeat (3) tick();
    reset_n = 1'b1;
    #1;
    check("rst_pred_taken", {15'd0, bpi.if_pred_taken}, 16'h0000);
    check("rst_pred_pc", bpi.if_pred_pc, 16'h0011);
    check("rst_mispredict", {15'd0, bpi.mispredict}, 16'h0000);
    check("rst_redirect", bpi.redirect_pc, 16'h0000);

    tick();
    set_ex(1'b1, 1'b1, 1'b0, 16'h0010, 1'b1, 16'h0040, 16'h0011);
    #1;
    check("alloc_mispredict", {15'd0, bpi.mispredict}, 16'h0001);
    check("alloc_redirect", bpi.redirect_pc, 16'h0040);
    check("alloc_same_cycle_taken", {15'd0, bpi.if_pred_taken}, 16'h0000);
    tick();
    idle();
    #1;
    check("alloc_next_pred_pc", bpi.if_pred_pc, 16'h0040);
    check("alloc_next_taken", {15'd0, bpi.if_pred_taken}, 16'h0001);

    set_ex(1'b1, 1'b1, 1'b0, 16'h0010, 1'b0, 16'h0040, 16'h0040);
    #1;
    check("nt1_mispredict", {15'd0, bpi.mispredict}, 16'h0001);
    check("nt1_redirect", bpi.redirect_pc, 16'h0011);
    tick();
    check("nt1_pred_taken", {15'd0, bpi.if_pred_taken}, 16'h0000);
    check("nt1_pred_pc", bpi.if_pred_pc, 16'h0011);
    set_ex(1'b1, 1'b1, 1'b0, 16'h0010, 1'b0, 16'h0040, 16'h0011);
    #1;
    check("nt2_mispredict", {15'd0, bpi.mispredict}, 16'h0000);
    tick();
    check("nt2_pred_taken", {15'd0, bpi.if_pred_taken}, 16'h0000);

    for (int i = 0; i < 4; i++) begin
      set_ex(1'b1, 1'b1, 1'b0, 16'h0010, 1'b1, 16'h0040, 16'h0011);
      tick();
    end
    idle();
    #1;
    check("sat_taken", {15'd0, bpi.if_pred_taken}, 16'h0001);
    check("sat_pred_pc", bpi.if_pred_pc, 16'h0040);
    set_ex(1'b1, 1'b1, 1'b0, 16'h0010, 1'b0, 16'h0040, 16'h0040);
    tick();
    idle();
    #1;
    check("sat_minus1_taken", {15'd0, bpi.if_pred_taken}, 16'h0001);

    bpi.if_pc = 16'h0025;
    set_ex(1'b1, 1'b0, 1'b1, 16'h0025, 1'b0, 16'h0100, 16'h0026);
    #1;
    check("jmp_mispredict", {15'd0, bpi.mispredict}, 16'h0001);
    check("jmp_redirect", bpi.redirect_pc, 16'h0100);
    tick();
    check("jmp_pred_pc", bpi.if_pred_pc, 16'h0100);
    set_ex(1'b1, 1'b0, 1'b1, 16'h0025, 1'b0, 16'h0100, 16'h0100);
    #1;
    check("jmp_correct", {15'd0, bpi.mispredict}, 16'h0000);
    tick();

    bpi.if_pc = 16'h0010;
    set_ex(1'b1, 1'b1, 1'b0, 16'h0030, 1'b1, 16'h0080, 16'h0031);
    #1;
    check("rbw_old_pred_pc", bpi.if_pred_pc, 16'h0040);
    check("alias_mispredict", {15'd0, bpi.mispredict}, 16'h0001);
    check("alias_redirect", bpi.redirect_pc, 16'h0080);
    tick();
    idle();
    #1;
    check("alias_evicted_pc", bpi.if_pred_pc, 16'h0011);
    check("alias_evicted_taken", {15'd0, bpi.if_pred_taken}, 16'h0000);
    bpi.if_pc = 16'h0030;
    #1;
    check("alias_new_pred_pc", bpi.if_pred_pc, 16'h0080);

    bpi.if_pc = 16'h0047;
    set_ex(1'b1, 1'b1, 1'b0, 16'h0047, 1'b0, 16'h0090, 16'h0048);
    #1;
    check("miss_nt_mispredict", {15'd0, bpi.mispredict}, 16'h0000);
    check("miss_nt_redirect", bpi.redirect_pc, 16'h0048);
    tick();
    check("miss_nt_no_alloc", {15'd0, bpi.if_pred_taken}, 16'h0000);

    bpi.if_pc = 16'h0052;
    set_ex(1'b0, 1'b1, 1'b0, 16'h0052, 1'b1, 16'h0090, 16'h0053);
    #1;
    check("inval_mispredict", {15'd0, bpi.mispredict}, 16'h0000);
    check("inval_redirect", bpi.redirect_pc, 16'h0000);
    tick();
    check("inval_no_alloc", bpi.if_pred_pc, 16'h0053);

    set_ex(1'b1, 1'b0, 1'b0, 16'h0060, 1'b1, 16'h0090, 16'h0099);
    #1;
    check("nonbr_mispredict", {15'd0, bpi.mispredict}, 16'h0000);
    check("nonbr_redirect", bpi.redirect_pc, 16'h0061);

    bpi.if_pc = 16'hFFFF;
    #1;
    check("wrap_pred_pc", bpi.if_pred_pc, 16'h0000);

    bpi.if_pc = 16'h0030;
    set_ex(1'b1, 1'b1, 1'b0, 16'h0030, 1'b0, 16'h0080, 16'h0080);
    #1;
    reset_n = 1'b0;
    #1;
    check("midrst_taken", {15'd0, bpi.if_pred_taken}, 16'h0000);
    check("midrst_pred_pc", bpi.if_pred_pc, 16'h0031);
    check("midrst_mispredict", {15'd0, bpi.mispredict}, 16'h0000);
    check("midrst_redirect", bpi.redirect_pc, 16'h0000);
`ifdef BP_STATS_EN
    check("midrst_stat_br", stat_branches, 16'h0000);
    check("midrst_stat_mp", stat_mispredicts, 16'h0000);
`endif
    idle();
    tick();
    reset_n = 1'b1;
    bpi.if_pc = 16'h0025;
    #1;
    check("post_rst_jmp_gone", {15'd0, bpi.if_pred_taken}, 16'h0000);

`ifdef BP_STATS_EN
    set_ex(1'b1, 1'b1, 1'b0, 16'h0070, 1'b1, 16'h00A0, 16'h0071);
    tick();
    set_ex(1'b1, 1'b0, 1'b1, 16'h0072, 1'b0, 16'h00B0, 16'h0073);
    tick();
    set_ex(1'b1, 1'b1, 1'b0, 16'h0074, 1'b0, 16'h00C0, 16'h0075);
    tick();
    idle();
    #1;
    check("stat_branches", stat_branches, 16'h0003);
    check("stat_mispredicts", stat_mispredicts, 16'h0002);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Dynamic branch predictor and resolver. Sits directly downstream of the EX-stage branch decision logic and feeds the IF-stage PC mux.
- IF side: direct-mapped BTB lookup with 2-bit saturating counters produces the predicted next PC.
- EX side: consumes the resolved taken/not-taken decision and the branch target. Updates the BTB and counters, and raises flush/redirect on a mispredict.

Parameters:
- WORD_SIZE, 16, width of PC, target and instruction words.
- IDX_W, 4, BTB index width; ENTRIES = 2**IDX_W.
- CTR_INIT, 2'b10, counter value written on a new allocation (weakly taken).

Ports:
- clk  input  1  pipeline clock; all state updates on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- if_pc  input  WORD_SIZE  PC of the instruction being fetched.
- if_pred_pc  output  WORD_SIZE  predicted next fetch PC.
- if_pred_taken  output  1  prediction was taken (BTB hit and counter >= 2).
- ex_valid  input  1  EX stage holds a real (non-bubble, non-stalled) instruction.
- ex_is_branch  input  1  EX instruction is conditional (BNE/BEQ/BGZ/BLZ).
- ex_is_jump  input  1  EX instruction is an unconditional direct jump (JMP/JAL).
- ex_pc  input  WORD_SIZE  PC of the EX instruction.
- ex_taken  input  1  resolved decision from the branch decision stage.
- ex_target  input  WORD_SIZE  computed branch/jump target.
- ex_pred_pc  input  WORD_SIZE  next-PC predicted for this instruction, carried down the pipe.
- mispredict  output  1  flush IF/ID and ID/EX this cycle.
- redirect_pc  output  WORD_SIZE  correct next PC when mispredict = 1.

Behaviour:
- Index and tag:
  - idx = pc[IDX_W-1:0]
  - tag = pc[WORD_SIZE-1:IDX_W]
- Each BTB entry holds valid, tag, target and a 2-bit counter.
- IF lookup is combinational:
  - hit = valid[idx] && tag match.
  - if_pred_taken = hit && ctr[idx][1].
  - if_pred_pc = if_pred_taken ? target[idx] : if_pc + 1 (16-bit wrap; 16'hFFFF+1 = 0).
- EX resolve is combinational, same cycle as the decision:
  - actual_next = (ex_is_jump || (ex_is_branch && ex_taken)) ? ex_target : ex_pc + 1.
  - mispredict = ex_valid && (ex_is_branch || ex_is_jump) && (actual_next != ex_pred_pc).
  - redirect_pc = actual_next whenever ex_valid; 0 otherwise.
  - Any non-branch instruction drives mispredict = 0.
- EX update is registered and applies only when ex_valid:
  - Branch hit, taken: ctr = min(ctr+1, 3); target refreshed.
  - Branch hit, not taken: ctr = max(ctr-1, 0).
  - Branch miss, taken: allocate entry (valid=1, tag, target, ctr=CTR_INIT), evicting any prior occupant.
  - Branch miss, not taken: no allocation, no change.
  - Jump: allocate or refresh the entry with ctr = 2'b11 and the target.
  - ex_valid = 0: no state change.
- Simultaneous IF lookup and EX update to the same index: the lookup sees pre-update contents (read-before-write). The update is visible from the next cycle.
- Reset (asynchronous, any cycle, including mid-update):
  - All valid bits = 0, all counters = 2'b01.
  - Target and tag contents need no reset.
  - Outputs during reset: if_pred_taken = 0, if_pred_pc = if_pc + 1, mispredict = 0, redirect_pc = 0.
  - An update pending in the reset cycle is discarded.
- Latency: prediction 0 cycles; resolve/flush 0 cycles; table update 1 cycle.

Optional Feature:
- Macro: BP_STATS_EN.
- Defined: two 16-bit registered counters, stat_branches and stat_mispredicts, plus matching output ports.
  - stat_branches increments each cycle ex_valid && (ex_is_branch || ex_is_jump).
  - stat_mispredicts increments each cycle mispredict = 1.
  - Both saturate at 16'hFFFF and clear on reset_n = 0.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset, then if_pc=16'h0010 -> if_pred_taken=0, if_pred_pc=16'h0011; mispredict=0.
- Branch at ex_pc=16'h0010, taken, ex_target=16'h0040, ex_pred_pc=16'h0011 -> mispredict=1, redirect_pc=16'h0040. Next cycle if_pc=16'h0010 -> if_pred_pc=16'h0040, if_pred_taken=1.
- Same branch resolved not-taken twice (ctr 2->1->0). After the first: if_pred_taken=0; ex_pred_pc=16'h0040 -> mispredict=1, redirect_pc=16'h0011. Four taken resolutions then saturate ctr at 3.
- Aliasing: branch at 16'h0030 (idx 0, different tag) taken to 16'h0080 -> evicts entry; lookup 16'h0010 -> miss, if_pred_pc=16'h0011.
- Same-cycle lookup/update on idx 0 -> lookup returns old entry; new entry seen next cycle. ex_valid=0 with taken inputs -> no mispredict, no table change.
- Assert reset_n low mid-run -> all predictions not-taken immediately. With BP_STATS_EN: 3 branches, 2 mispredicts -> stat_branches=3, stat_mispredicts=2, both 0 after reset.
